fir_mac_serial: RTL



---
 rtl/fir_mac_serial_pkg.sv | 29 ++
 rtl/fir_delay_bank.sv | 45 ++++
 rtl/fir_mac_serial.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/fir_mac_serial_pkg.sv
// Shared types and constant helpers for the serial multi-channel FIR.
// Result struct fields are sized for the widest supported build; users cast down.
package fir_mac_types;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    OUT
  } fir_state_e;

  localparam int unsigned RES_CHAN_MAX = 8;
  localparam int unsigned RES_DATA_MAX = 32;

  typedef struct packed {
    logic        [RES_CHAN_MAX-1:0] chan;
    logic signed [RES_DATA_MAX-1:0] data;
  } fir_result_t;

  // Unity gain in the Q format implied by the output shift.
  function automatic logic [63:0] identity_coef(input int unsigned out_shift);
    return 64'd1 << out_shift;
  endfunction

  // Half an output LSB, added before the arithmetic shift.
  function automatic logic [63:0] round_const(input int unsigned out_shift);
    return 64'd1 << (out_shift - 1);
  endfunction

endpackage

// File: rtl/fir_delay_bank.sv
// Per-channel sample history: channel-addressed shift-in, tap-indexed read.
// Tap 0 holds the newest sample; the oldest falls off the end.
module fir_delay_bank
  import fir_mac_types::*;
#(
  parameter int DATA_W   = 16,
  parameter int TAPS     = 4,
  parameter int CHANNELS = 2,
  parameter int CW       = 1,
  parameter int TW       = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     shift_en,
  input  logic [CW-1:0]            shift_chan,
  input  logic signed [DATA_W-1:0] shift_data,
  input  logic [CW-1:0]            rd_chan,
  input  logic [TW-1:0]            rd_tap,
  output logic signed [DATA_W-1:0] rd_data
);

  logic signed [DATA_W-1:0] line_q [CHANNELS][TAPS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        for (int unsigned t = 0; t < TAPS; t++) begin
          line_q[c][t] <= '0;
        end
      end
    end else if (shift_en) begin
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        if (CW'(c) == shift_chan) begin
          line_q[c][0] <= shift_data;
          for (int unsigned t = 1; t < TAPS; t++) begin
            line_q[c][t] <= line_q[c][t-1];
          end
        end
      end
    end
  end

  assign rd_data = line_q[rd_chan][rd_tap];

endmodule

// File: rtl/fir_mac_serial.sv
// Time-multiplexed multi-channel FIR: one MAC per cycle, TAPS cycles per sample,
// shared run-time coefficient bank, valid/ready on both sides.
module fir_mac_serial
  import fir_mac_types::*;
#(
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 16,
  parameter int TAPS      = 4,
  parameter int CHANNELS  = 2,
  parameter int OUT_SHIFT = 14,
  parameter int ACC_W     = DATA_W + COEF_W + $clog2(TAPS),
  parameter int CW        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                       system1000,
  input  logic                       system1000_rstn,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [DATA_W-1:0]   in_data,
  input  logic [CW-1:0]              in_chan,
  input  logic                       coef_we,
  input  logic [$clog2(TAPS)-1:0]    coef_addr,
  input  logic signed [COEF_W-1:0]   coef_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [DATA_W-1:0]   out_data,
  output logic [CW-1:0]              out_chan
);

  localparam int AW = $clog2(TAPS);
  localparam int PW = DATA_W + COEF_W;

  localparam logic signed [COEF_W-1:0] ID_COEF = COEF_W'(identity_coef(OUT_SHIFT));
  localparam logic signed [ACC_W-1:0]  RND     = ACC_W'(round_const(OUT_SHIFT));
  localparam logic signed [ACC_W-1:0]  SAT_MAX =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0]  SAT_MIN =
    {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  fir_state_e state_q, state_d;

  logic signed [COEF_W-1:0] coef_q [TAPS];
  logic [CW-1:0]            chan_q;
  logic [AW-1:0]            k_q;
  logic signed [ACC_W-1:0]  acc_q;
  fir_result_t              res_q;

  logic                     chan_ok;
  logic                     accept;
  logic                     last_tap;
  logic signed [DATA_W-1:0] x_k;
  logic signed [PW-1:0]     prod;
  logic signed [ACC_W-1:0]  acc_sum;
  logic signed [ACC_W-1:0]  rounded;
  logic signed [DATA_W-1:0] sat_val;

  assign in_ready = (state_q == IDLE) && system1000_rstn;
  assign chan_ok  = int'(in_chan) < CHANNELS;
  // Out-of-range channels still handshake so the source never stalls on them.
  assign accept   = in_valid && in_ready && chan_ok;
  assign last_tap = (state_q == MAC) && (k_q == AW'(TAPS - 1));

  fir_delay_bank #(
    .DATA_W   (DATA_W),
    .TAPS     (TAPS),
    .CHANNELS (CHANNELS),
    .CW       (CW),
    .TW       (AW)
  ) u_delay_bank (
    .clk        (system1000),
    .rst_n      (system1000_rstn),
    .shift_en   (accept),
    .shift_chan (in_chan),
    .shift_data (in_data),
    .rd_chan    (chan_q),
    .rd_tap     (k_q),
    .rd_data    (x_k)
  );

  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept)    state_d = MAC;
      MAC:     if (last_tap)  state_d = OUT;
      OUT:     if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      for (int unsigned t = 0; t < TAPS; t++) begin
        coef_q[t] <= (t == 0) ? ID_COEF : '0;
      end
    end else if (coef_we && state_q == IDLE && int'(coef_addr) < TAPS) begin
      coef_q[coef_addr] <= coef_data;
    end
  end

  // Final product is folded in combinationally so the result lands on the TAPS-th edge.
  assign prod    = x_k * coef_q[k_q];
  assign acc_sum = acc_q + ACC_W'(prod);
  assign rounded = (acc_sum + RND) >>> OUT_SHIFT;

  always_comb begin
    sat_val = rounded[DATA_W-1:0];
    if (rounded > SAT_MAX) begin
      sat_val = SAT_MAX[DATA_W-1:0];
    end else if (rounded < SAT_MIN) begin
      sat_val = SAT_MIN[DATA_W-1:0];
    end
  end

  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      chan_q <= '0;
      k_q    <= '0;
      acc_q  <= '0;
      res_q  <= '0;
    end else if (accept) begin
      chan_q <= in_chan;
      k_q    <= '0;
      acc_q  <= '0;
    end else if (state_q == MAC) begin
      acc_q <= acc_sum;
      k_q   <= k_q + AW'(1);
      if (last_tap) begin
        res_q.chan <= RES_CHAN_MAX'(chan_q);
        res_q.data <= RES_DATA_MAX'(sat_val);
      end
    end
  end

  assign out_valid = (state_q == OUT);
  assign out_data  = DATA_W'(res_q.data);
  assign out_chan  = CW'(res_q.chan);

endmodule
